// File: rtl/ecd_row_receiver.sv
// Row-data receiver for the ECD master return stream: delimits rows, checks row length
// and row-ID sequence, and forwards beats downstream through a 2-entry registered skid buffer.
module ecd_row_receiver #(
    parameter int          DW        = 256,
    parameter int          ROW_BEATS = 32,
    parameter logic [31:0] SEQ_START = 32'h0000_C008
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic [DW-1:0] AXIS_RX_TDATA,
    input  logic          AXIS_RX_TVALID,
    input  logic          AXIS_RX_TLAST,
    output logic          AXIS_RX_TREADY,
    output logic [DW-1:0] AXIS_TX_TDATA,
    output logic          AXIS_TX_TVALID,
    output logic          AXIS_TX_TLAST,
    input  logic          AXIS_TX_TREADY,
    output logic          row_complete_out,
    output logic [31:0]   rows_received,
    output logic [15:0]   short_rows,
    output logic [15:0]   long_rows,
    output logic [15:0]   seq_errors,
    output logic          idle_out
);

    localparam int             BCW       = $clog2(ROW_BEATS);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(ROW_BEATS - 1);

    logic          rx_ready_reg, rx_ready_next;
    logic          tx_valid_reg, tx_valid_next;
    logic [DW-1:0] tx_data_reg, tx_data_next;
    logic          tx_last_reg, tx_last_next;
    logic          skid_valid_reg, skid_valid_next;
    logic [DW-1:0] skid_data_reg, skid_data_next;
    logic          skid_last_reg, skid_last_next;

    logic [BCW-1:0] beat_count_reg, beat_count_next;
    logic [31:0]    expected_id_reg, expected_id_next;
    logic [31:0]    rows_received_reg, rows_received_next;
    logic           row_complete_reg, row_complete_next;

    logic           accept;
    logic           row_end;
    logic           at_last_beat;
    logic [2:0]     err_inc;
    logic [2:0][15:0] err_cnt;

    assign accept       = AXIS_RX_TVALID && rx_ready_reg;
    assign at_last_beat = (beat_count_reg == LAST_BEAT);
    assign row_end      = AXIS_RX_TLAST || at_last_beat;

    // Skid buffer: the output register always holds the oldest beat; the skid register only
    // fills when a beat arrives while the output is stalled.
    always_comb begin
        tx_valid_next   = tx_valid_reg;
        tx_data_next    = tx_data_reg;
        tx_last_next    = tx_last_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_last_next  = skid_last_reg;
        if (!tx_valid_reg || AXIS_TX_TREADY) begin
            if (skid_valid_reg) begin
                tx_valid_next   = 1'b1;
                tx_data_next    = skid_data_reg;
                tx_last_next    = skid_last_reg;
                skid_valid_next = accept;
                skid_data_next  = AXIS_RX_TDATA;
                skid_last_next  = row_end;
            end else begin
                tx_valid_next = accept;
                tx_data_next  = AXIS_RX_TDATA;
                tx_last_next  = row_end;
            end
        end else if (accept) begin
            skid_valid_next = 1'b1;
            skid_data_next  = AXIS_RX_TDATA;
            skid_last_next  = row_end;
        end
        rx_ready_next = !(tx_valid_next && skid_valid_next);
    end

    // Row tracking; clear wins over a same-cycle accept, which is still forwarded above.
    always_comb begin
        beat_count_next    = beat_count_reg;
        expected_id_next   = expected_id_reg;
        rows_received_next = rows_received_reg;
        row_complete_next  = 1'b0;
        err_inc            = '0;
        if (clear) begin
            beat_count_next    = '0;
            expected_id_next   = SEQ_START;
            rows_received_next = '0;
        end else if (accept) begin
            if (beat_count_reg == '0) begin
                err_inc[2]       = (AXIS_RX_TDATA[31:0] != expected_id_reg);
                expected_id_next = AXIS_RX_TDATA[31:0] + 32'd1;
            end
            if (row_end) begin
                beat_count_next    = '0;
                rows_received_next = rows_received_reg + 32'd1;
                row_complete_next  = 1'b1;
                err_inc[0]         = AXIS_RX_TLAST && !at_last_beat;
                err_inc[1]         = !AXIS_RX_TLAST && at_last_beat;
            end else begin
                beat_count_next = beat_count_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ready_reg      <= 1'b0;
            tx_valid_reg      <= 1'b0;
            tx_data_reg       <= '0;
            tx_last_reg       <= 1'b0;
            skid_valid_reg    <= 1'b0;
            skid_data_reg     <= '0;
            skid_last_reg     <= 1'b0;
            beat_count_reg    <= '0;
            expected_id_reg   <= SEQ_START;
            rows_received_reg <= '0;
            row_complete_reg  <= 1'b0;
        end else begin
            rx_ready_reg      <= rx_ready_next;
            tx_valid_reg      <= tx_valid_next;
            tx_data_reg       <= tx_data_next;
            tx_last_reg       <= tx_last_next;
            skid_valid_reg    <= skid_valid_next;
            skid_data_reg     <= skid_data_next;
            skid_last_reg     <= skid_last_next;
            beat_count_reg    <= beat_count_next;
            expected_id_reg   <= expected_id_next;
            rows_received_reg <= rows_received_next;
            row_complete_reg  <= row_complete_next;
        end
    end

    // Saturating error counters: 0 = short rows, 1 = long rows, 2 = sequence errors.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_err_cnt
            logic [15:0] cnt_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (clear) begin
                    cnt_reg <= '0;
                end else if (err_inc[gi] && (cnt_reg != 16'hFFFF)) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
            assign err_cnt[gi] = cnt_reg;
        end
    endgenerate

    assign AXIS_RX_TREADY   = rx_ready_reg;
    assign AXIS_TX_TDATA    = tx_data_reg;
    assign AXIS_TX_TVALID   = tx_valid_reg;
    assign AXIS_TX_TLAST    = tx_last_reg;
    assign row_complete_out = row_complete_reg;
    assign rows_received    = rows_received_reg;
    assign short_rows       = err_cnt[0];
    assign long_rows        = err_cnt[1];
    assign seq_errors       = err_cnt[2];
    assign idle_out         = !tx_valid_reg && !skid_valid_reg && (beat_count_reg == '0);

endmodule

// File: tb/tb_ecd_row_receiver.sv
// Randomised bench for ecd_row_receiver: every beat is scored against a row-level model
// of the stream (expected output queue, per-row counters, buffer occupancy).
module tb_ecd_row_receiver;

    localparam int          DW   = 256;
    localparam int          RB   = 32;
    localparam logic [31:0] SEQ0 = 32'h0000_C008;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic [DW-1:0] AXIS_RX_TDATA = '0;
    logic          AXIS_RX_TVALID = 1'b0;
    logic          AXIS_RX_TLAST = 1'b0;
    logic          AXIS_RX_TREADY;
    logic [DW-1:0] AXIS_TX_TDATA;
    logic          AXIS_TX_TVALID;
    logic          AXIS_TX_TLAST;
    logic          AXIS_TX_TREADY = 1'b1;
    logic          row_complete_out;
    logic [31:0]   rows_received;
    logic [15:0]   short_rows;
    logic [15:0]   long_rows;
    logic [15:0]   seq_errors;
    logic          idle_out;

    ecd_row_receiver #(.DW(DW), .ROW_BEATS(RB), .SEQ_START(SEQ0)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .AXIS_RX_TDATA(AXIS_RX_TDATA), .AXIS_RX_TVALID(AXIS_RX_TVALID),
        .AXIS_RX_TLAST(AXIS_RX_TLAST), .AXIS_RX_TREADY(AXIS_RX_TREADY),
        .AXIS_TX_TDATA(AXIS_TX_TDATA), .AXIS_TX_TVALID(AXIS_TX_TVALID),
        .AXIS_TX_TLAST(AXIS_TX_TLAST), .AXIS_TX_TREADY(AXIS_TX_TREADY),
        .row_complete_out(row_complete_out), .rows_received(rows_received),
        .short_rows(short_rows), .long_rows(long_rows), .seq_errors(seq_errors),
        .idle_out(idle_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t       exp_q[$];
    int          m_pos = 0;
    logic [31:0] m_id = SEQ0;
    int          m_rows = 0, m_short = 0, m_long = 0, m_seq = 0;
    int          m_pulses = 0, dut_pulses = 0, occ = 0;
    bit          mon_en = 0;
    bit          rand_rdy = 0;
    logic        tx_rdy_dir = 1'b1;

    task automatic model_clear();
        m_pos = 0; m_id = SEQ0;
        m_rows = 0; m_short = 0; m_long = 0; m_seq = 0;
    endtask

    task automatic model_accept(input logic [DW-1:0] d, input logic l, input logic clr);
        bit row_end;
        row_end = l || (m_pos == RB - 1);
        exp_q.push_back('{d, row_end});
        if (clr) return;
        if (m_pos == 0) begin
            if (d[31:0] != m_id) m_seq++;
            m_id = d[31:0] + 32'd1;
        end
        if (row_end) begin
            m_rows++; m_pulses++;
            if (l && m_pos < RB - 1) m_short++;
            if (!l) m_long++;
            m_pos = 0;
        end else begin
            m_pos++;
        end
    endtask

    // Scoreboard/monitor, sampled on the falling edge.
    always @(negedge clk) begin : mon
        bit    acc, pop;
        beat_t b;
        if (!reset) begin
            pop = AXIS_TX_TVALID && AXIS_TX_TREADY;
            acc = AXIS_RX_TVALID && AXIS_RX_TREADY;
            if (mon_en) check_val("rx_ready", AXIS_RX_TREADY, occ < 2);
            if (row_complete_out) dut_pulses++;
            if (pop) begin
                if (exp_q.size() == 0) begin
                    check_val("tx_extra_beat", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    check_val("tx_data", AXIS_TX_TDATA, b.d);
                    check_val("tx_last", AXIS_TX_TLAST, b.l);
                end
            end
            if (acc) model_accept(AXIS_RX_TDATA, AXIS_RX_TLAST, clear);
            if (clear) model_clear();
            occ += int'(acc) - int'(pop);
        end
    end

    always @(posedge clk) begin
        #1;
        AXIS_TX_TREADY = rand_rdy ? 1'($urandom_range(0, 1)) : tx_rdy_dir;
    end

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic send(input logic [DW-1:0] d, input logic l);
        int w;
        bit a;
        w = 0;
        AXIS_RX_TVALID = 1'b1; AXIS_RX_TDATA = d; AXIS_RX_TLAST = l;
        forever begin
            @(negedge clk);
            a = AXIS_RX_TREADY;
            @(posedge clk); #1;
            if (a) break;
            w++;
            if (w > 200) begin check_val("rx_accept_timeout", 0, 1); break; end
        end
    endtask

    task automatic send_row(input int n, input bit with_last, input logic [31:0] id);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd();
            if (i == 0) d[31:0] = id;
            send(d, with_last && (i == n - 1));
        end
    endtask

    task automatic rx_idle();
        AXIS_RX_TVALID = 1'b0; AXIS_RX_TLAST = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && occ == 0) break;
            @(posedge clk); #1;
        end
        repeat (2) begin @(posedge clk); #1; end
        check_val("drain_queue", exp_q.size(), 0);
    endtask

    task automatic check_counters(input string tag);
        check_val({tag, ".rows"}, rows_received, m_rows);
        check_val({tag, ".short"}, short_rows, m_short);
        check_val({tag, ".long"}, long_rows, m_long);
        check_val({tag, ".seq"}, seq_errors, m_seq);
        check_val({tag, ".pulses"}, dut_pulses, m_pulses);
        check_val({tag, ".idle"}, idle_out, (m_pos == 0) && (occ == 0));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [DW-1:0] d;
        logic [31:0]   cur;
        int            total, n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst.rx_ready", AXIS_RX_TREADY, 0);
        check_val("rst.tx_valid", AXIS_TX_TVALID, 0);
        check_val("rst.pulse", row_complete_out, 0);
        check_val("rst.rows", rows_received, 0);
        check_val("rst.errs", {short_rows, long_rows, seq_errors}, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check_val("rst.rx_ready_rise", AXIS_RX_TREADY, 1);
        check_val("rst.idle", idle_out, 1);
        mon_en = 1;

        // Four well-formed rows, with a one-cycle latency check on the first beat
        d = rnd(); d[31:0] = SEQ0;
        send(d, 1'b0);
        check_val("t1.latency_valid", AXIS_TX_TVALID, 1);
        check_val("t1.latency_data", AXIS_TX_TDATA, d);
        for (int i = 1; i < RB; i++) send(rnd(), i == RB - 1);
        for (int r = 1; r < 4; r++) send_row(RB, 1, SEQ0 + 32'(r));
        rx_idle(); drain();
        check_counters("t1");
        check_val("t1.rows_const", rows_received, 4);

        // Short row then full row
        pulse_clear();
        send_row(10, 1, SEQ0);
        send_row(RB, 1, SEQ0 + 1);
        rx_idle(); drain();
        check_counters("t2");
        check_val("t2.short_const", short_rows, 1);

        // 40 beats without TLAST: long row, beat 32 starts a new row
        pulse_clear();
        send_row(RB, 0, SEQ0);
        send_row(8, 0, SEQ0 + 1);
        rx_idle(); drain();
        check_counters("t3");
        check_val("t3.long_const", long_rows, 1);
        check_val("t3.idle_mid_row", idle_out, 0);

        // Sequence gap C008, C00A, C00B
        pulse_clear();
        send_row(RB, 1, SEQ0);
        send_row(RB, 1, SEQ0 + 2);
        send_row(RB, 1, SEQ0 + 3);
        rx_idle(); drain();
        check_counters("t4");
        check_val("t4.seq_const", seq_errors, 1);

        // Random TX backpressure, random row lengths and occasional bad IDs
        pulse_clear();
        rand_rdy = 1;
        cur = SEQ0; total = 0;
        while (total < 256) begin
            n = $urandom_range(1, 40);
            if ($urandom_range(0, 5) == 0) cur = $urandom;
            send_row(n, $urandom_range(0, 2) != 0, cur);
            cur = cur + 1;
            total += n;
        end
        rx_idle();
        rand_rdy = 0;
        drain();
        check_counters("t5");

        // clear coincident with an accepted mid-row beat
        pulse_clear();
        send_row(5, 0, SEQ0);
        clear = 1'b1;
        send(rnd(), 1'b0);
        clear = 1'b0;
        rx_idle(); drain();
        check_counters("t6.after_clear");
        check_val("t6.rows_zero", rows_received, 0);
        send_row(RB, 1, SEQ0);
        rx_idle(); drain();
        check_counters("t6");
        check_val("t6.seq_const", seq_errors, 0);

        // Reset while the skid buffer is full
        tx_rdy_dir = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        send_row(2, 0, SEQ0);
        rx_idle();
        @(posedge clk); #1;
        check_val("t7.buffer_full", AXIS_RX_TREADY, 0);
        #3 reset = 1'b1;
        #2;
        check_val("t7.async_tx_valid", AXIS_TX_TVALID, 0);
        check_val("t7.async_rx_ready", AXIS_RX_TREADY, 0);
        mon_en = 0;
        exp_q.delete();
        occ = 0;
        model_clear();
        tx_rdy_dir = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check_val("t7.rx_ready_rise", AXIS_RX_TREADY, 1);
        check_val("t7.idle", idle_out, 1);
        mon_en = 1;
        send_row(RB, 1, SEQ0);
        rx_idle(); drain();
        check_counters("t7");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ecd_row_receiver.md
Name: ecd_row_receiver

Overview:
Consumes the 256-bit row-data AXI-Stream that the ECD master returns in answer to row requests. Delimits rows, checks row length and row sequence, and forwards data downstream through a registered skid buffer. Emits a one-cycle row_complete_out pulse per row, which drives the request generator's row_complete_in flow control.

Parameters:
DW, 256, stream data width in bits (multiple of 32)
ROW_BEATS, 32, beats per well-formed row (>=2)
SEQ_START, 32'h0000_C008, expected row ID carried in the first beat after clear/reset

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
clear  in  1  sync pulse: restart row/sequence tracking, zero counters
AXIS_RX_TDATA  in  DW  row data from ECD master
AXIS_RX_TVALID  in  1  RX valid
AXIS_RX_TLAST  in  1  RX end-of-row marker
AXIS_RX_TREADY  out  1  RX ready (registered)
AXIS_TX_TDATA  out  DW  forwarded data
AXIS_TX_TVALID  out  1  TX valid
AXIS_TX_TLAST  out  1  regenerated end-of-row
AXIS_TX_TREADY  in  1  TX ready
row_complete_out  out  1  one-cycle pulse per row ended
rows_received  out  32  rows ended since clear (wraps)
short_rows  out  16  rows ended by TLAST before ROW_BEATS (saturating)
long_rows  out  16  rows reaching ROW_BEATS with TLAST low (saturating)
seq_errors  out  16  first-beat row-ID mismatches (saturating)
idle_out  out  1  high when skid buffer empty and beat_count==0

Behaviour:
- Reset (async assert, sync deassert into logic):
  - All counters 0; row_complete_out 0; AXIS_TX_TVALID 0; AXIS_RX_TREADY 0.
  - AXIS_RX_TREADY rises the first cycle after reset deasserts.
  - expected_id = SEQ_START; beat_count = 0.
- Accept = AXIS_RX_TVALID & AXIS_RX_TREADY. All tracking happens on input accept.
- Skid buffer:
  - 2 entries; AXIS_RX_TREADY is registered and high when fewer than 2 entries are held.
  - Output is registered: 1-cycle latency from accept to AXIS_TX_TVALID when empty.
  - Full throughput with TREADY held high. No data loss or duplication under any TREADY pattern.
  - TDATA/TLAST stable while TVALID & !TREADY.
- Row delimiting, beat_count range 0..ROW_BEATS-1. On accept:
  - row_end = RX_TLAST | (beat_count == ROW_BEATS-1).
  - If row_end: beat_count <= 0, otherwise beat_count <= beat_count + 1.
  - Forwarded TX_TLAST = row_end.
- Classification on row_end:
  - TLAST with beat_count < ROW_BEATS-1: short_rows += 1.
  - beat_count == ROW_BEATS-1 with TLAST low: long_rows += 1. The next beat starts a new row.
  - Exact match: no error.
  - All cases: rows_received += 1; row_complete_out pulses the cycle after the accept.
- Sequence check on the first beat of a row (beat_count == 0):
  - Compare TDATA[31:0] to expected_id; on mismatch, seq_errors += 1.
  - expected_id <= TDATA[31:0] + 1 (resynchronises to the received ID).
- Single-beat row: first beat with TLAST and ROW_BEATS > 1 gets both the sequence check and short classification.
- Error counters saturate at 16'hFFFF. rows_received wraps 2^32-1 → 0.
- clear:
  - Zeroes all counters, beat_count and the pending row_complete_out pulse; expected_id <= SEQ_START.
  - Has priority over the same-cycle accept: that beat is forwarded unchanged but not counted or checked.
  - Skid buffer contents are not flushed.
- Reset mid-row or mid-transfer discards buffered data; TX_TVALID drops asynchronously.

Test Plan:
- ROW_BEATS=32, 4 rows of 32 beats with TLAST on beat 31, IDs C008..C00B, TX_TREADY=1 → 128 beats out in order, 4 pulses, rows_received=4, all error counters 0, 1-cycle latency.
- Row with TLAST on beat 9 (10 beats) followed by a full row → short_rows=1, rows_received=2, TX_TLAST on output beats 9 and 41.
- 40 beats, no TLAST → TX_TLAST on beat 31, long_rows=1, beat 32 checked as new row ID.
- IDs C008, C00A, C00B → seq_errors=1 (C00A), C00B accepted as in-sequence.
- Random TX_TREADY (50%) with continuous RX valid over 256 beats → output equals input and TLAST positions match; RX_TREADY never drops while buffer holds <2 entries.
- clear asserted coincident with an accepted beat mid-row → counters 0, beat forwarded, next beat checked against C008.
